// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, per-format constants and the
// payload structs carried between the int2fp pipeline stages.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int MAX_IW = 64;
  localparam int MAX_EW = 11;

  function automatic int fw_of(input int w);
    return (w == 32) ? 23 : 52;
  endfunction

  function automatic int ew_of(input int w);
    return (w == 32) ? 8 : 11;
  endfunction

  function automatic int bias_of(input int w);
    return (w == 32) ? 127 : 1023;
  endfunction

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [MAX_IW-1:0] mag;
    rm_e               rm;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [MAX_EW-1:0] exp;
    logic [MAX_IW-1:0] norm;
    rm_e               rm;
  } s2_t;

endpackage

// File: rtl/find_first_set.sv
// Leading-one detector: pos is the index of the most significant set bit
// of vec (0 when vec is zero).
module find_first_set #(
  parameter int LG_N = 6
) (
  input  logic [(1<<LG_N)-1:0] vec,
  output logic [LG_N-1:0]      pos
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < (1 << LG_N); i++) begin
      if (vec[i]) pos = LG_N'(i);
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Final int2fp stage: extracts mantissa/guard/sticky from the normalised
// magnitude, rounds (only when INT2FP_ROUND_EN is defined) and packs.
module fp_round_pack
  import fpu_pkg::*;
#(
  parameter int IW = 64,
  parameter int W  = 64
) (
  input  logic              sign,
  input  logic              zero,
  input  logic [MAX_EW-1:0] exp,
  input  logic [IW-1:0]     norm,
  input  rm_e               rm,
  output logic [W-1:0]      fp,
  output logic              nx
);

  localparam int FW = fw_of(W);
  localparam int EW = ew_of(W);

  logic [FW-1:0] mant;
  logic          guard;
  logic          sticky;
  logic [FW-1:0] mant_r;
  logic [EW-1:0] exp_r;

  // norm[IW-1] is the implicit leading one and never reaches the result.
  generate
    if (IW - 1 > FW + 1) begin : g_round
      logic unused_lead;
      assign unused_lead = norm[IW-1];
      assign mant   = norm[IW-2 -: FW];
      assign guard  = norm[IW-2-FW];
      assign sticky = |norm[IW-3-FW:0];
    end else begin : g_exact
      logic unused_lead;
      assign unused_lead = norm[IW-1];
      assign mant   = {norm[IW-2:0], {(FW-IW+1){1'b0}}};
      assign guard  = 1'b0;
      assign sticky = 1'b0;
    end
  endgenerate

  assign nx = guard | sticky;

`ifdef INT2FP_ROUND_EN
  logic        round_up;
  logic [FW:0] mant_sum;

  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & nx;
      RM_RUP:  round_up = !sign & nx;
      RM_RMM:  round_up = guard;
      default: round_up = guard & (sticky | mant[0]);
    endcase
  end

  // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
  assign mant_sum = {1'b0, mant} + (FW+1)'(round_up);
  assign mant_r   = mant_sum[FW-1:0];
  assign exp_r    = exp[EW-1:0] + EW'(mant_sum[FW]);
`else
  logic unused_rm;
  assign unused_rm = ^rm;
  assign mant_r    = mant;
  assign exp_r     = exp[EW-1:0];
`endif

  assign fp = zero ? '0 : {sign, exp_r, mant_r};

endmodule

// File: rtl/int2fp_pipe.sv
// Three-stage integer-to-float converter with valid/ready backpressure,
// tag passthrough and flush. Define INT2FP_ROUND_EN for IEEE rounding; else RTZ.
module int2fp_pipe
  import fpu_pkg::*;
#(
  parameter int IW    = 64,
  parameter int W     = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_int,
  input  logic             in_signed,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_fp,
  output logic             out_nx,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LG_N = $clog2(IW);
  localparam int BIAS = bias_of(W);

  // Handshake: a stage loads when it is empty or its occupant moves on, so
  // in_ready chains combinationally back from out_ready; a beat transfers on
  // any clk edge where valid && ready.
  logic s1_valid, s2_valid;
  logic out_adv, s2_ld, s1_ld;

  assign out_adv  = !out_valid || out_ready;
  assign s2_ld    = !s2_valid || out_adv;
  assign s1_ld    = !s1_valid || s2_ld;
  assign in_ready = s1_ld && !flush;

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [IW-1:0]    mag;
  logic             sgn;

  assign sgn = in_signed & in_int[IW-1];
  assign mag = sgn ? (~in_int + IW'(1)) : in_int;

`ifdef INT2FP_ROUND_EN
  rm_e rm_n;
  assign rm_n = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);
`else
  rm_e  rm_n;
  logic unused_rm;
  assign unused_rm = ^in_rm;
  assign rm_n      = RM_RTZ;
`endif

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sgn;
    s1_d.zero = (in_int == '0);
    s1_d.mag  = MAX_IW'(mag);
    s1_d.rm   = rm_n;
  end

  logic [IW-1:0]   s1_mag;
  logic [LG_N-1:0] lead;
  logic [IW-1:0]   norm;

  assign s1_mag = s1_q.mag[IW-1:0];

  find_first_set #(.LG_N(LG_N)) u_ffs (
    .vec (s1_mag),
    .pos (lead)
  );

  // For power-of-two IW, ~lead equals IW-1-lead.
  assign norm = s1_mag << (~lead);

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.exp  = MAX_EW'(BIAS) + MAX_EW'(lead);
    s2_d.norm = MAX_IW'(norm);
    s2_d.rm   = s1_q.rm;
  end

  logic [W-1:0] rp_fp;
  logic         rp_nx;

  fp_round_pack #(.IW(IW), .W(W)) u_round_pack (
    .sign (s2_q.sign),
    .zero (s2_q.zero),
    .exp  (s2_q.exp),
    .norm (s2_q.norm[IW-1:0]),
    .rm   (s2_q.rm),
    .fp   (rp_fp),
    .nx   (rp_nx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      out_fp    <= '0;
      out_nx    <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_ld) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q   <= s1_d;
          s1_tag <= in_tag;
        end
      end
      if (s2_ld) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_q   <= s2_d;
          s2_tag <= s1_tag;
        end
      end
      if (out_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_fp  <= rp_fp;
          out_nx  <= rp_nx;
          out_tag <= s2_tag;
        end
      end
    end
  end

endmodule
